// File: rtl/wsum_argmax_acc.sv
// rtl/wsum_argmax_acc.sv - saturating per-column accumulator with argmax readout over a frame of beats
// Accumulates NUM_STEPS beats of eight column sums, scans one column per cycle for the maximum, then holds the result.
module wsum_argmax_acc #(
  parameter int NUM_STEPS = 4,
  parameter int ACC_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      w_sum11,
  input  logic [11:0]      w_sum12,
  input  logic [11:0]      w_sum13,
  input  logic [11:0]      w_sum14,
  input  logic [11:0]      w_sum15,
  input  logic [11:0]      w_sum16,
  input  logic [11:0]      w_sum17,
  input  logic [11:0]      w_sum18,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       win_idx,
  output logic [ACC_W-1:0] win_val,
  output logic             acc_sat
);

  typedef enum logic [1:0] {ST_ACC, ST_SCAN, ST_OUT} state_t;

  localparam logic [7:0]       LAST_BEAT = 8'(NUM_STEPS - 1);
  localparam logic [ACC_W-1:0] ACC_MAX   = '1;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [2:0]       scan_q, scan_d;
  logic [ACC_W-1:0] acc_q [8];
  logic [ACC_W-1:0] acc_d [8];
  logic             sat_q, sat_d;
  logic [ACC_W-1:0] best_val_q, best_val_d;
  logic [2:0]       best_idx_q, best_idx_d;
  logic [2:0]       win_idx_q, win_idx_d;
  logic [ACC_W-1:0] win_val_q, win_val_d;
  logic             acc_sat_q, acc_sat_d;
  logic             out_valid_q, out_valid_d;

  logic [11:0]      w_in [8];
  logic [ACC_W:0]   sum [8];
  logic             beat;
  logic             take;
  logic [ACC_W-1:0] cand_val;
  logic [2:0]       cand_idx;

  assign w_in[0] = w_sum11;
  assign w_in[1] = w_sum12;
  assign w_in[2] = w_sum13;
  assign w_in[3] = w_sum14;
  assign w_in[4] = w_sum15;
  assign w_in[5] = w_sum16;
  assign w_in[6] = w_sum17;
  assign w_in[7] = w_sum18;

  // in_ready is a pure function of state and rst so out_ready never reaches it.
  assign in_ready  = (state_q == ST_ACC) && !rst;
  assign beat      = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign win_idx   = win_idx_q;
  assign win_val   = win_val_q;
  assign acc_sat   = acc_sat_q;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      sum[i] = {1'b0, acc_q[i]} + (ACC_W + 1)'(w_in[i]);
    end
    // Strict compare keeps the lowest index on ties.
    take     = (scan_q == 3'd0) || (acc_q[scan_q] > best_val_q);
    cand_val = take ? acc_q[scan_q] : best_val_q;
    cand_idx = take ? scan_q : best_idx_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    scan_d      = scan_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    win_idx_d   = win_idx_q;
    win_val_d   = win_val_q;
    acc_sat_d   = acc_sat_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_ACC: begin
        if (beat) begin
          if (cnt_q == 8'd0) begin
            for (int i = 0; i < 8; i++) begin
              acc_d[i] = ACC_W'(w_in[i]);
            end
            sat_d = 1'b0;
          end else begin
            for (int i = 0; i < 8; i++) begin
              if (sum[i][ACC_W]) begin
                acc_d[i] = ACC_MAX;
                sat_d    = 1'b1;
              end else begin
                acc_d[i] = sum[i][ACC_W-1:0];
              end
            end
          end
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = 8'd0;
            scan_d  = 3'd0;
            state_d = ST_SCAN;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_SCAN: begin
        best_val_d = cand_val;
        best_idx_d = cand_idx;
        scan_d     = scan_q + 3'd1;
        if (scan_q == 3'd7) begin
          win_idx_d   = cand_idx;
          win_val_d   = cand_val;
          acc_sat_d   = sat_q;
          out_valid_d = 1'b1;
          scan_d      = 3'd0;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      cnt_q       <= 8'd0;
      scan_q      <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        acc_q[i] <= '0;
      end
      sat_q       <= 1'b0;
      best_val_q  <= '0;
      best_idx_q  <= 3'd0;
      win_idx_q   <= 3'd0;
      win_val_q   <= '0;
      acc_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      scan_q      <= scan_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      win_idx_q   <= win_idx_d;
      win_val_q   <= win_val_d;
      acc_sat_q   <= acc_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_wsum_argmax_acc.sv
// tb/tb_wsum_argmax_acc.sv - vector table, directed sequences and random frames against a column-sum model
module tb_wsum_argmax_acc;

  typedef logic [7:0][11:0] beat_t;
  typedef logic [7:0][7:0][11:0] frame_t;
  typedef struct {
    frame_t     beats;
    logic [2:0] idx;
    longint     val;
    logic       sat;
  } vec_t;

  logic  clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst;
  beat_t bus;
  logic  in_valid_a, in_valid_s, out_ready_a, out_ready_s;
  logic  in_ready_a, in_ready_s, out_valid_a, out_valid_s;
  logic  acc_sat_a, acc_sat_s;
  logic [2:0]  win_idx_a, win_idx_s;
  logic [15:0] win_val_a;
  logic [11:0] win_val_s;

  int n_vec = 0;
  int n_err = 0;

  wsum_argmax_acc #(.NUM_STEPS(4), .ACC_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .w_sum11(bus[0]), .w_sum12(bus[1]), .w_sum13(bus[2]), .w_sum14(bus[3]),
    .w_sum15(bus[4]), .w_sum16(bus[5]), .w_sum17(bus[6]), .w_sum18(bus[7]),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .win_idx(win_idx_a), .win_val(win_val_a), .acc_sat(acc_sat_a)
  );

  wsum_argmax_acc #(.NUM_STEPS(8), .ACC_W(12)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .w_sum11(bus[0]), .w_sum12(bus[1]), .w_sum13(bus[2]), .w_sum14(bus[3]),
    .w_sum15(bus[4]), .w_sum16(bus[5]), .w_sum17(bus[6]), .w_sum18(bus[7]),
    .out_valid(out_valid_s), .out_ready(out_ready_s),
    .win_idx(win_idx_s), .win_val(win_val_s), .acc_sat(acc_sat_s)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic ird(bit s);    return s ? in_ready_s : in_ready_a;   endfunction
  function automatic logic ov(bit s);     return s ? out_valid_s : out_valid_a; endfunction
  function automatic logic [2:0] wi(bit s); return s ? win_idx_s : win_idx_a;   endfunction
  function automatic longint wv(bit s);   return s ? longint'(win_val_s) : longint'(win_val_a); endfunction
  function automatic logic wsat(bit s);   return s ? acc_sat_s : acc_sat_a;     endfunction

  function automatic beat_t mk(int col, int v, int others);
    beat_t b;
    for (int c = 0; c < 8; c++) b[c] = (c == col) ? 12'(v) : 12'(others);
    return b;
  endfunction

  function automatic frame_t rep(beat_t b);
    frame_t f;
    for (int i = 0; i < 8; i++) f[i] = b;
    return f;
  endfunction

  // Column totals with a ceiling, then first-maximum search.
  function automatic void model(frame_t f, int n, int accw,
                                output logic [2:0] idx, output longint val, output logic sat);
    longint maxv = (longint'(1) << accw) - 1;
    longint tot [8];
    sat = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tot[c] = 0;
      for (int i = 0; i < n; i++) tot[c] += longint'(f[i][c]);
      if (tot[c] > maxv) begin
        tot[c] = maxv;
        sat    = 1'b1;
      end
    end
    idx = 3'd0;
    val = tot[0];
    for (int c = 1; c < 8; c++) begin
      if (tot[c] > val) begin
        idx = 3'(c);
        val = tot[c];
      end
    end
  endfunction

  task automatic set_valid(bit s, logic v);
    if (s) in_valid_s = v; else in_valid_a = v;
  endtask

  task automatic set_oready(bit s, logic v);
    if (s) out_ready_s = v; else out_ready_a = v;
  endtask

  task automatic send_beat(bit s, beat_t b, int gap);
    int g = 0;
    repeat (gap) begin @(posedge clk); #1; end
    bus = b;
    set_valid(s, 1'b1);
    while (!ird(s) && g < 100) begin @(posedge clk); #1; g++; end
    if (g >= 100) chk("in_ready_timeout", ird(s), 1);
    @(posedge clk); #1;
    set_valid(s, 1'b0);
  endtask

  task automatic collect(bit s, int hold, output logic [2:0] idx, output longint val, output logic sat);
    int lat = 0;
    logic rdy_seen = 1'b0;
    while (!ov(s) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (ird(s)) rdy_seen = 1'b1;
    end
    chk("latency", lat, 8);
    chk("in_ready_during_scan", rdy_seen, 0);
    idx = wi(s); val = wv(s); sat = wsat(s);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", ov(s), 1);
      chk("hold_idx", wi(s), idx);
      chk("hold_val", wv(s), val);
      chk("hold_in_ready", ird(s), 0);
    end
    set_oready(s, 1'b1);
    @(posedge clk); #1;
    set_oready(s, 1'b0);
    chk("out_valid_after_hs", ov(s), 0);
    chk("in_ready_after_hs", ird(s), 1);
    chk("idx_kept_after_hs", wi(s), idx);
  endtask

  task automatic run_frame(bit s, frame_t f, int n, int gapmax, int hold,
                           logic [2:0] eidx, longint eval, logic esat, string nm);
    logic [2:0] idx;
    longint     val;
    logic       sat;
    for (int i = 0; i < n; i++) send_beat(s, f[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
    collect(s, hold, idx, val, sat);
    chk({nm, "_idx"}, idx, eidx);
    chk({nm, "_val"}, val, eval);
    chk({nm, "_sat"}, sat, esat);
  endtask

  task automatic pulse_rst(int cycles);
    rst = 1'b1;
    repeat (cycles) begin @(posedge clk); #1; end
    chk("rst_in_ready_a", in_ready_a, 0);
    chk("rst_out_valid_a", out_valid_a, 0);
    chk("rst_win_idx_a", win_idx_a, 0);
    chk("rst_win_val_a", win_val_a, 0);
    chk("rst_acc_sat_a", acc_sat_a, 0);
    chk("rst_out_valid_s", out_valid_s, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", in_ready_a, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t       tbl [5];
    beat_t      b;
    frame_t     f;
    logic [2:0] eidx;
    longint     eval;
    logic       esat;
    int         quiet;

    b = '0; b[1] = 12'd900; b[5] = 12'd900;
    tbl[0] = '{rep(mk(2, 100, 10)), 3'd2, 400, 1'b0};
    tbl[1] = '{rep(b), 3'd1, 3600, 1'b0};
    tbl[2] = '{rep('0), 3'd0, 0, 1'b0};
    tbl[3] = '{rep(mk(7, 7, 0)), 3'd7, 28, 1'b0};
    tbl[4] = '{rep(mk(0, 4095, 4095)), 3'd0, 16380, 1'b0};

    rst = 1'b1; bus = '0;
    in_valid_a = 0; in_valid_s = 0; out_ready_a = 0; out_ready_s = 0;
    @(posedge clk); #1;
    pulse_rst(2);

    for (int i = 0; i < 5; i++) run_frame(0, tbl[i].beats, 4, 0, 0, tbl[i].idx, tbl[i].val, tbl[i].sat, $sformatf("tbl%0d", i));

    // Beats arrive with in_valid pattern 1,0,0,1,1,0,1 and the result is held off for 5 cycles.
    for (int i = 0; i < 4; i++) f[i] = mk(3, 20 * (i + 1), i);
    send_beat(0, f[0], 0);
    send_beat(0, f[1], 2);
    send_beat(0, f[2], 0);
    send_beat(0, f[3], 1);
    begin
      logic [2:0] ri; longint rv; logic rs;
      model(f, 4, 16, eidx, eval, esat);
      collect(0, 5, ri, rv, rs);
      chk("gap_idx", ri, eidx);
      chk("gap_val", rv, eval);
    end
    run_frame(0, rep(mk(7, 7, 0)), 4, 0, 0, 3'd7, 28, 1'b0, "no_carry");

    run_frame(1, rep(mk(0, 900, 900)), 8, 0, 1, 3'd0, 4095, 1'b1, "sat");
    run_frame(1, rep(mk(0, 1, 1)), 8, 0, 0, 3'd0, 8, 1'b0, "sat_clear");

    // Reset in the middle of a scan discards the frame and clears the held result.
    for (int i = 0; i < 4; i++) send_beat(0, mk(6, 300, 1), 0);
    repeat (3) begin @(posedge clk); #1; end
    pulse_rst(2);
    quiet = 0;
    repeat (12) begin @(posedge clk); #1; if (out_valid_a) quiet++; end
    chk("no_result_after_scan_rst", quiet, 0);

    send_beat(0, mk(3, 500, 0), 0);
    send_beat(0, mk(3, 500, 0), 0);
    pulse_rst(1);
    run_frame(0, rep(mk(4, 50, 0)), 4, 0, 0, 3'd4, 200, 1'b0, "after_mid_rst");

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 4; i++)
        for (int c = 0; c < 8; c++)
          case ($urandom_range(0, 3))
            0:       f[i][c] = 12'd100;
            1:       f[i][c] = 12'd4095;
            default: f[i][c] = 12'($urandom_range(0, 4095));
          endcase
      model(f, 4, 16, eidx, eval, esat);
      run_frame(0, f, 4, 2, int'($urandom_range(0, 3)), eidx, eval, esat, $sformatf("rand_a%0d", k));
    end

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++)
        for (int c = 0; c < 8; c++) f[i][c] = 12'($urandom_range(0, 700));
      model(f, 8, 12, eidx, eval, esat);
      run_frame(1, f, 8, 1, int'($urandom_range(0, 2)), eidx, eval, esat, $sformatf("rand_s%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
